// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Mealy stall/flush generation with a 3-state FSM.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  ID_RS1,
  input  logic [4:0]  ID_RS2,
  input  logic        ID_USE_RS1,
  input  logic        ID_USE_RS2,
  input  logic [2:0]  EX_MEM_READ,
  input  logic [4:0]  EX_RD,
  input  logic        BRANCH_TAKEN,
  input  logic        IMEM_BUSY,
  input  logic        DMEM_BUSY,
  output logic        PC_HOLD,
  output logic        IFID_HOLD,
  output logic        IDEX_HOLD,
  output logic        EXMEM_HOLD,
  output logic        MEMWB_HOLD,
  output logic        IFID_FLUSH,
  output logic        IDEX_FLUSH,
  output logic [31:0] STALL_CNT,
  output logic [31:0] FLUSH_CNT
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   load_use;
  logic   branch_flush;

  // A load writing x0 never creates a dependency.
  assign load_use = (EX_MEM_READ != 3'b000) && (EX_RD != 5'd0) &&
                    ((ID_USE_RS1 && (ID_RS1 == EX_RD)) ||
                     (ID_USE_RS2 && (ID_RS2 == EX_RD)));

  assign branch_flush = BRANCH_TAKEN && !DMEM_BUSY;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= RUN;
    else        state_q <= state_d;
  end

  // MEM_WAIT behaves exactly like RUN once the data memory releases.
  always_comb begin
    state_d    = RUN;
    PC_HOLD    = 1'b0;
    IFID_HOLD  = 1'b0;
    IDEX_HOLD  = 1'b0;
    EXMEM_HOLD = 1'b0;
    MEMWB_HOLD = 1'b0;
    IFID_FLUSH = 1'b0;
    IDEX_FLUSH = 1'b0;
    if (!RESET) begin
      IFID_FLUSH = 1'b1;
      IDEX_FLUSH = 1'b1;
    end else if (DMEM_BUSY) begin
      PC_HOLD    = 1'b1;
      IFID_HOLD  = 1'b1;
      IDEX_HOLD  = 1'b1;
      EXMEM_HOLD = 1'b1;
      MEMWB_HOLD = 1'b1;
      state_d    = MEM_WAIT;
    end else if (BRANCH_TAKEN) begin
      IFID_FLUSH = 1'b1;
      IDEX_FLUSH = 1'b1;
    end else if (load_use && (state_q != LU_STALL)) begin
      PC_HOLD    = 1'b1;
      IFID_HOLD  = 1'b1;
      IDEX_FLUSH = 1'b1;
      state_d    = LU_STALL;
    end else if (IMEM_BUSY) begin
      PC_HOLD    = 1'b1;
      IFID_FLUSH = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Plain 32-bit adds wrap naturally from all-ones to zero.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (PC_HOLD || MEMWB_HOLD) stall_cnt_d = stall_cnt_q + 32'd1;
    if (branch_flush)          flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`else
  logic unused_branch_flush;
  assign unused_branch_flush = branch_flush;
  assign STALL_CNT = 32'd0;
  assign FLUSH_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; counter expectations follow HAZARD_PERF_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector order: {PC, IFID_H, IDEX_H, EXMEM_H, MEMWB_H, IFID_F, IDEX_F}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1100001;
  localparam logic [6:0] O_BR   = 7'b0000011;
  localparam logic [6:0] O_DMEM = 7'b1111100;
  localparam logic [6:0] O_IMEM = 7'b1000010;
  localparam logic [6:0] O_RST  = 7'b0000011;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  ID_RS1, ID_RS2, EX_RD;
  logic        ID_USE_RS1, ID_USE_RS2;
  logic [2:0]  EX_MEM_READ;
  logic        BRANCH_TAKEN, IMEM_BUSY, DMEM_BUSY;
  logic        PC_HOLD, IFID_HOLD, IDEX_HOLD, EXMEM_HOLD, MEMWB_HOLD;
  logic        IFID_FLUSH, IDEX_FLUSH;
  logic [31:0] STALL_CNT, FLUSH_CNT;
  logic [6:0]  outs;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_stall = 32'd0;
  logic [31:0] exp_flush = 32'd0;

  hazard_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_USE_RS1(ID_USE_RS1), .ID_USE_RS2(ID_USE_RS2),
    .EX_MEM_READ(EX_MEM_READ), .EX_RD(EX_RD),
    .BRANCH_TAKEN(BRANCH_TAKEN), .IMEM_BUSY(IMEM_BUSY), .DMEM_BUSY(DMEM_BUSY),
    .PC_HOLD(PC_HOLD), .IFID_HOLD(IFID_HOLD), .IDEX_HOLD(IDEX_HOLD),
    .EXMEM_HOLD(EXMEM_HOLD), .MEMWB_HOLD(MEMWB_HOLD),
    .IFID_FLUSH(IFID_FLUSH), .IDEX_FLUSH(IDEX_FLUSH),
    .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
  );

  assign outs = {PC_HOLD, IFID_HOLD, IDEX_HOLD, EXMEM_HOLD, MEMWB_HOLD, IFID_FLUSH, IDEX_FLUSH};

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    ID_RS1 = 5'd0; ID_RS2 = 5'd0; EX_RD = 5'd0;
    ID_USE_RS1 = 1'b0; ID_USE_RS2 = 1'b0; EX_MEM_READ = 3'b000;
    BRANCH_TAKEN = 1'b0; IMEM_BUSY = 1'b0; DMEM_BUSY = 1'b0;
  endtask

  task automatic set_load_use_rs1();
    EX_MEM_READ = 3'b010; EX_RD = 5'd5; ID_RS1 = 5'd5; ID_USE_RS1 = 1'b1;
  endtask

  // Advance one edge; ds/df are the counter increments expected at that edge.
  task automatic tick(input int ds, input int df);
    @(posedge CLK);
    if (PERF) begin
      exp_stall = exp_stall + 32'(ds);
      exp_flush = exp_flush + 32'(df);
    end
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    RESET = 1'b0;
    #1;
    n_checks++; if (outs !== O_RST) $display("FAIL reset_outs: got %b want %b", outs, O_RST); else n_pass++;
    DMEM_BUSY = 1'b1; BRANCH_TAKEN = 1'b1;
    tick(0, 0); tick(0, 0);
    n_checks++; if (outs !== O_RST) $display("FAIL reset_dominates: got %b want %b", outs, O_RST); else n_pass++;
    n_checks++; if (STALL_CNT !== 32'd0 || FLUSH_CNT !== 32'd0) $display("FAIL reset_cnt: got %0d/%0d want 0/0", STALL_CNT, FLUSH_CNT); else n_pass++;
    clear_inputs();
    RESET = 1'b1;
    #1;
    n_checks++; if (outs !== O_NONE) $display("FAIL after_reset_idle: got %b want %b", outs, O_NONE); else n_pass++;
    tick(0, 0);
  endtask

  task automatic test_load_use();
    set_load_use_rs1();
    #1;
    n_checks++; if (outs !== O_LU) $display("FAIL lu_rs1_detect: got %b want %b", outs, O_LU); else n_pass++;
    tick(1, 0);
    n_checks++; if (outs !== O_NONE) $display("FAIL lu_masked_in_stall: got %b want %b", outs, O_NONE); else n_pass++;
    tick(0, 0);
    clear_inputs();
    #1;
    n_checks++; if (outs !== O_NONE) $display("FAIL lu_back_to_run: got %b want %b", outs, O_NONE); else n_pass++;
    EX_MEM_READ = 3'b100; EX_RD = 5'd17; ID_RS2 = 5'd17; ID_USE_RS2 = 1'b1;
    #1;
    n_checks++; if (outs !== O_LU) $display("FAIL lu_rs2_detect: got %b want %b", outs, O_LU); else n_pass++;
    tick(1, 0);
    clear_inputs();
    tick(0, 0);
    // Register match without the use flag is not a hazard.
    set_load_use_rs1(); ID_USE_RS1 = 1'b0;
    #1;
    n_checks++; if (outs !== O_NONE) $display("FAIL lu_unused_src: got %b want %b", outs, O_NONE); else n_pass++;
    clear_inputs();
    EX_MEM_READ = 3'b010; EX_RD = 5'd0; ID_RS2 = 5'd0; ID_USE_RS2 = 1'b1;
    #1;
    n_checks++; if (outs !== O_NONE) $display("FAIL lu_x0_load: got %b want %b", outs, O_NONE); else n_pass++;
    tick(0, 0);
    clear_inputs();
    n_checks++; if (STALL_CNT !== exp_stall) $display("FAIL lu_stall_cnt: got %0d want %0d", STALL_CNT, exp_stall); else n_pass++;
  endtask

  task automatic test_branch_vs_lu();
    set_load_use_rs1(); BRANCH_TAKEN = 1'b1;
    #1;
    n_checks++; if (outs !== O_BR) $display("FAIL br_over_lu: got %b want %b", outs, O_BR); else n_pass++;
    tick(0, 1);
    BRANCH_TAKEN = 1'b0;
    #1;
    // Still a live load-use: stalling now shows the branch left the FSM in RUN.
    n_checks++; if (outs !== O_LU) $display("FAIL br_next_is_run: got %b want %b", outs, O_LU); else n_pass++;
    tick(1, 0);
    clear_inputs();
    tick(0, 0);
    n_checks++; if (FLUSH_CNT !== exp_flush) $display("FAIL br_flush_cnt: got %0d want %0d", FLUSH_CNT, exp_flush); else n_pass++;
  endtask

  task automatic test_dmem_wait();
    set_load_use_rs1(); DMEM_BUSY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (outs !== O_DMEM) $display("FAIL dmem_hold_%0d: got %b want %b", i, outs, O_DMEM); else n_pass++;
      tick(1, 0);
    end
    n_checks++; if (STALL_CNT !== exp_stall) $display("FAIL dmem_stall_cnt: got %0d want %0d", STALL_CNT, exp_stall); else n_pass++;
    DMEM_BUSY = 1'b0;
    #1;
    n_checks++; if (outs !== O_LU) $display("FAIL dmem_lu_resumes: got %b want %b", outs, O_LU); else n_pass++;
    tick(1, 0);
    n_checks++; if (outs !== O_NONE) $display("FAIL dmem_lu_single_bubble: got %b want %b", outs, O_NONE); else n_pass++;
    tick(0, 0);
    clear_inputs();
    // A branch frozen during the wait acts exactly once after release.
    DMEM_BUSY = 1'b1; BRANCH_TAKEN = 1'b1;
    #1;
    n_checks++; if (outs !== O_DMEM) $display("FAIL dmem_over_branch: got %b want %b", outs, O_DMEM); else n_pass++;
    tick(1, 0);
    DMEM_BUSY = 1'b0;
    #1;
    n_checks++; if (outs !== O_BR) $display("FAIL dmem_release_branch: got %b want %b", outs, O_BR); else n_pass++;
    tick(0, 1);
    clear_inputs();
    n_checks++; if (STALL_CNT !== exp_stall || FLUSH_CNT !== exp_flush) $display("FAIL dmem_counters: got %0d/%0d want %0d/%0d", STALL_CNT, FLUSH_CNT, exp_stall, exp_flush); else n_pass++;
  endtask

  task automatic test_imem();
    IMEM_BUSY = 1'b1;
    #1;
    n_checks++; if (outs !== O_IMEM) $display("FAIL imem_wait: got %b want %b", outs, O_IMEM); else n_pass++;
    tick(1, 0);
    BRANCH_TAKEN = 1'b1;
    #1;
    n_checks++; if (outs !== O_BR) $display("FAIL imem_branch_redirect: got %b want %b", outs, O_BR); else n_pass++;
    tick(0, 1);
    BRANCH_TAKEN = 1'b0; set_load_use_rs1();
    #1;
    n_checks++; if (outs !== O_LU) $display("FAIL imem_lu_priority: got %b want %b", outs, O_LU); else n_pass++;
    tick(1, 0);
    #1;
    n_checks++; if (outs !== O_IMEM) $display("FAIL imem_in_lu_stall: got %b want %b", outs, O_IMEM); else n_pass++;
    tick(1, 0);
    clear_inputs();
    #1;
    n_checks++; if (outs !== O_NONE) $display("FAIL imem_idle: got %b want %b", outs, O_NONE); else n_pass++;
    n_checks++; if (STALL_CNT !== exp_stall || FLUSH_CNT !== exp_flush) $display("FAIL imem_counters: got %0d/%0d want %0d/%0d", STALL_CNT, FLUSH_CNT, exp_stall, exp_flush); else n_pass++;
  endtask

  task automatic test_async_reset();
    DMEM_BUSY = 1'b1;
    tick(1, 0);
    #2;
    RESET = 1'b0;
    #1;
    exp_stall = 32'd0; exp_flush = 32'd0;
    n_checks++; if (outs !== O_RST) $display("FAIL async_reset_outs: got %b want %b", outs, O_RST); else n_pass++;
    n_checks++; if (STALL_CNT !== 32'd0 || FLUSH_CNT !== 32'd0) $display("FAIL async_reset_cnt: got %0d/%0d want 0/0", STALL_CNT, FLUSH_CNT); else n_pass++;
    tick(0, 0);
    DMEM_BUSY = 1'b0; RESET = 1'b1; set_load_use_rs1();
    #1;
    n_checks++; if (outs !== O_LU) $display("FAIL async_reset_from_run: got %b want %b", outs, O_LU); else n_pass++;
    tick(1, 0);
    clear_inputs();
    tick(0, 0);
    n_checks++; if (STALL_CNT !== exp_stall) $display("FAIL post_reset_cnt: got %0d want %0d", STALL_CNT, exp_stall); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_vs_lu();
    test_dmem_wait();
    test_imem();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
